hms_clock: RTL and testbench
============================

# hms_clock

Time-of-day accumulator fed by the decade/modulo counter stage. It consumes that stage's one-cycle carry pulse as `tick` and keeps hours, minutes and seconds in packed BCD. A valid/ready load port sets the time, a day-rollover pulse feeds downstream, and an optional alarm comparator can be compiled in.

## Interface
- `HOURS_24`, default 1: 1 gives hours 00–23; 0 gives 12-hour mode, hours 01–12, no AM/PM bit.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `tick` in 1: advance one second; sampled every `clk`, one increment per high cycle.
- `run` in 1: 1 means ticks counted; 0 means ticks ignored (load still works).
- `load_valid` in 1: load request.
- `load_ready` out 1: block can accept a load.
- `load_time` in 24: {hh,mm,ss} packed BCD, two digits each.
- `load_done` out 1: one-cycle pulse, load committed.
- `load_err` out 1: one-cycle pulse, load rejected.
- `alarm_wr` in 1: write alarm register.
- `alarm_time` in 16: {hh,mm} packed BCD.
- `hour` out 8, `min` out 8, `sec` out 8: current time, packed BCD.
- `min_carry` out 1: one-cycle pulse on ss 59→00.
- `day_pulse` out 1: one-cycle pulse on the last rollover (23:59:59→00:00:00, or 12:59:59→01:00:00 in 12-hour mode).
- `alarm_hit` out 1: one-cycle alarm pulse.

## Operation
- **Reset values**
  - `sec` and `min` reset to 00; `hour` resets to 00 (24-hour mode) or 12 (12-hour mode).
  - `load_ready` resets to 1; every pulse output resets to 0.
  - Alarm register resets to 00:00, disarmed.
- **Increment** on a cycle with `tick & run`:
  - ss+1; 59→00 raises `min_carry` and does mm+1.
  - mm 59→00 does hh+1.
  - hh wraps 23→00 (24-hour mode). In 12-hour mode hh goes 12→01, and 11→12 is a plain increment.
  - Each BCD digit carries at 9 to the next digit; no binary arithmetic on packed bytes.
- **Load FSM states**
  - IDLE: `load_ready`=1. `load_valid & load_ready` captures `load_time` into a shadow register and moves to CHECK.
  - CHECK: `load_ready`=0, lasts exactly one cycle. The shadow is validated: every digit ≤9, ss≤59, mm≤59, and hh≤23 (24-hour mode) or 01≤hh≤12 (12-hour mode).
  - Valid shadow: time registers take the shadow and `load_done` pulses.
  - Invalid shadow: the time is untouched and `load_err` pulses.
  - CHECK always returns to IDLE.
- **Tick versus load**
  - A tick on the CHECK cycle is dropped when the commit is valid (load wins) and applied normally when the load is rejected.
  - A tick on the accept cycle is applied, then overwritten by the commit.
  - Loads never raise `min_carry`, `day_pulse` or `alarm_hit`.
- **Alarm**
  - `alarm_wr` with a valid hh:mm stores it and arms the alarm. An invalid value is ignored and keeps the previous setting.
  - `alarm_hit` pulses on the cycle after a tick-driven increment makes the time equal hh:mm:00. The alarm stays armed.
- Illegal FSM encodings recover to IDLE.

## Timing
- Tick latency is 1: a tick sampled at edge k shows on `sec` after edge k. `min_carry` and `day_pulse` are registered and coincident with the new value.
- `alarm_hit` asserts one cycle after the matching time appears.
- Load latency: accept at edge k, commit at edge k+1, so the new time and `load_done`/`load_err` are visible after edge k+1.
- `load_ready` is low for exactly one cycle per accepted load, which allows one load every 2 cycles.
- `load_time` is only sampled at accept; changes after accept have no effect.
- A reset asserted mid-load aborts it: the FSM returns to IDLE with reset values and no done/err pulse.

## Configuration
- `HMS_ALARM_EN` defined: alarm register, comparator and `alarm_hit` logic are present.
- `HMS_ALARM_EN` undefined: alarm ports still exist, `alarm_wr` and `alarm_time` are ignored, and `alarm_hit` is tied to 0.

## Structure
- Package `hms_pkg` holds:
  - the FSM state typedef (IDLE, CHECK);
  - BCD limit constants (SEC_MAX 8'h59, MIN_MAX 8'h59, HR24_MAX 8'h23, HR12_MAX 8'h12, HR12_MIN 8'h01);
  - the BCD-validity check function.
- Sub-module `bcd2_counter`: a two-digit BCD counter with parameterised max and wrap value, carry-in, carry-out and synchronous load. It is instantiated once each for seconds, minutes and hours.

## Test plan
- **Reset and first tick:** reset, then run=1 with one tick → sec=01, min=00, hour=00, no pulses.
- **Midnight wrap:** load 23:59:58 and wait for load_done, then 2 ticks → 23:59:59, then 00:00:00 with min_carry=1 and day_pulse=1 for exactly one cycle.
- **Invalid loads:** 24:00:00, 12:60:00 and 12:3A:00 → each gives load_err one cycle, time unchanged, load_ready back to 1 on the next cycle.
- **Load/tick collision:** tick held high while a valid 10:20:30 load is accepted → time reads 10:20:30 after commit; the next tick gives 10:20:31.
- **12-hour mode:** HOURS_24=0, reset → hour=12; load 12:59:59 then tick → 01:00:00 with day_pulse=1. A separate load of 00:10:00 is rejected.
- **Alarm (with HMS_ALARM_EN):** alarm 07:30, load 07:29:59 then tick → alarm_hit one cycle after 07:30:00. Loading 07:30:00 directly gives no hit. Without the macro, alarm_hit stays 0.

Source files
------------

// File: rtl/hms_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hms_pkg
//  Description : Shared types, BCD limit constants and validity helpers for
//                the hms_clock time-of-day accumulator.
//                Contents:
//                  load_state_t - load FSM state encoding (IDLE, CHECK)
//                  *_MAX/_MIN   - packed-BCD limit constants
//                  bcd_ok       - both digits of a packed BCD byte are <= 9
//                  hm_ok        - hh:mm is a legal time for the hour mode
//                  time_ok      - hh:mm:ss is a legal time for the hour mode
//  Revision    : 1.0 - initial release
// ============================================================================
package hms_pkg;

    // One-hot style encoding so the unused codes (00, 11) can be detected
    // and steered back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        CHECK = 2'b10
    } load_state_t;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HR24_MAX = 8'h23;
    localparam logic [7:0] HR12_MAX = 8'h12;
    localparam logic [7:0] HR12_MIN = 8'h01;

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // With both digits already known to be decimal, a plain unsigned compare
    // of the packed byte orders the same way as the decimal value.
    function automatic logic hm_ok(input logic [7:0] hh,
                                   input logic [7:0] mm,
                                   input logic       hours24);
        logic hr_ok;
        if (hours24)
            hr_ok = (hh <= HR24_MAX);
        else
            hr_ok = (hh >= HR12_MIN) && (hh <= HR12_MAX);
        return bcd_ok(hh) && bcd_ok(mm) && (mm <= MIN_MAX) && hr_ok;
    endfunction

    function automatic logic time_ok(input logic [7:0] hh,
                                     input logic [7:0] mm,
                                     input logic [7:0] ss,
                                     input logic       hours24);
        return hm_ok(hh, mm, hours24) && bcd_ok(ss) && (ss <= SEC_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_counter
//  Description : Two-digit packed-BCD counter. Increments digit-wise (units
//                carry into tens at 9), wraps from MAX_VAL to WRAP_VAL and
//                reports the wrap on carry. A synchronous load has priority
//                over the increment and never produces a carry.
//  Ports       : clk      - clock, rising edge
//                rstn     - asynchronous active-low reset (value -> RST_VAL)
//                inc      - carry-in, advance by one this cycle
//                load     - replace the value with load_val
//                load_val - packed BCD value to load
//                value    - current packed BCD value
//                carry    - combinational carry-out, inc at MAX_VAL
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2_counter
    import hms_pkg::*;
#(
    parameter logic [7:0] MAX_VAL  = 8'h59,
    parameter logic [7:0] WRAP_VAL = 8'h00,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_d;
    logic       at_max;

    assign at_max = (value_q == MAX_VAL);

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            if (at_max)
                value_d = WRAP_VAL;
            else if (value_q[3:0] == 4'd9)
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            else
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            value_q <= RST_VAL;
        else
            value_q <= value_d;
    end

    assign value = value_q;
    assign carry = inc & ~load & at_max;

endmodule
`default_nettype wire

// File: rtl/hms_clock.sv
`default_nettype none
// ============================================================================
//  Module      : hms_clock
//  Description : Time-of-day accumulator in packed BCD (hh:mm:ss). Counts
//                one second per tick while run is high, accepts time loads
//                over a valid/ready port with a one-cycle validation stage,
//                and emits minute/day rollover pulses.
//                Optional feature macro: HMS_ALARM_EN - when defined, adds
//                an hh:mm alarm register and comparator driving alarm_hit;
//                when undefined, alarm_wr/alarm_time are ignored and
//                alarm_hit is tied low.
//  Parameters  : HOURS_24 - 1: hours 00..23, 0: hours 01..12
//  Ports       : clk, rstn          - clock, async active-low reset
//                tick, run          - one-second advance, count enable
//                load_valid/ready   - load handshake
//                load_time          - {hh,mm,ss} packed BCD to load
//                load_done/err      - one-cycle commit / reject pulses
//                alarm_wr/time      - alarm write, {hh,mm} packed BCD
//                hour, min, sec     - current time, packed BCD
//                min_carry          - pulse on ss 59->00
//                day_pulse          - pulse on the last-hour rollover
//                alarm_hit          - pulse one cycle after alarm match
//  Revision    : 1.0 - initial release
// ============================================================================
module hms_clock
    import hms_pkg::*;
#(
    parameter int HOURS_24 = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick,
    input  logic        run,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [23:0] load_time,
    output logic        load_done,
    output logic        load_err,
    input  logic        alarm_wr,
    input  logic [15:0] alarm_time,
    output logic [7:0]  hour,
    output logic [7:0]  min,
    output logic [7:0]  sec,
    output logic        min_carry,
    output logic        day_pulse,
    output logic        alarm_hit
);

    localparam logic       HR24    = (HOURS_24 != 0);
    localparam logic [7:0] HR_MAX  = HR24 ? HR24_MAX : HR12_MAX;
    localparam logic [7:0] HR_WRAP = HR24 ? 8'h00    : HR12_MIN;
    localparam logic [7:0] HR_RST  = HR24 ? 8'h00    : HR12_MAX;

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    load_state_t state_q;
    load_state_t state_d;
    logic [23:0] shadow_q;
    logic        shadow_ok;
    logic        accept;
    logic        commit_ok;
    logic        commit_bad;

    assign shadow_ok = time_ok(shadow_q[23:16], shadow_q[15:8], shadow_q[7:0], HR24);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        accept     = 1'b0;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                commit_ok  = shadow_ok;
                commit_bad = ~shadow_ok;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // load_time is captured only on accept; later changes are irrelevant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            shadow_q <= 24'h000000;
        else if (accept)
            shadow_q <= load_time;
    end

    // ------------------------------------------------------------------
    // Time counters. A valid commit wins over a same-cycle tick; a
    // rejected commit lets the tick through.
    // ------------------------------------------------------------------
    logic step;
    logic sec_carry;
    logic min_wrap;
    logic hr_wrap;

    assign step = tick & run & ~commit_ok;

    bcd2_counter #(
        .MAX_VAL  (SEC_MAX),
        .WRAP_VAL (8'h00),
        .RST_VAL  (8'h00)
    ) u_sec (
        .clk      (clk),
        .rstn     (rstn),
        .inc      (step),
        .load     (commit_ok),
        .load_val (shadow_q[7:0]),
        .value    (sec),
        .carry    (sec_carry)
    );

    bcd2_counter #(
        .MAX_VAL  (MIN_MAX),
        .WRAP_VAL (8'h00),
        .RST_VAL  (8'h00)
    ) u_min (
        .clk      (clk),
        .rstn     (rstn),
        .inc      (sec_carry),
        .load     (commit_ok),
        .load_val (shadow_q[15:8]),
        .value    (min),
        .carry    (min_wrap)
    );

    bcd2_counter #(
        .MAX_VAL  (HR_MAX),
        .WRAP_VAL (HR_WRAP),
        .RST_VAL  (HR_RST)
    ) u_hour (
        .clk      (clk),
        .rstn     (rstn),
        .inc      (min_wrap),
        .load     (commit_ok),
        .load_val (shadow_q[23:16]),
        .value    (hour),
        .carry    (hr_wrap)
    );

    // Pulses registered so they line up with the new counter values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            min_carry <= 1'b0;
            day_pulse <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            min_carry <= sec_carry;
            day_pulse <= hr_wrap;
            load_done <= commit_ok;
            load_err  <= commit_bad;
        end
    end

    // ------------------------------------------------------------------
    // Alarm
    // ------------------------------------------------------------------
`ifdef HMS_ALARM_EN
    logic [15:0] alarm_q;
    logic        armed_q;
    logic        stepped_q;
    logic        hit_q;

    // stepped_q marks that the time on display came from a tick, so a load
    // landing on the alarm time never fires it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alarm_q   <= 16'h0000;
            armed_q   <= 1'b0;
            stepped_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            if (alarm_wr && hm_ok(alarm_time[15:8], alarm_time[7:0], HR24)) begin
                alarm_q <= alarm_time;
                armed_q <= 1'b1;
            end
            stepped_q <= step;
            hit_q     <= stepped_q & armed_q & ({hour, min, sec} == {alarm_q, 8'h00});
        end
    end

    assign alarm_hit = hit_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_wr, alarm_time};
    assign alarm_hit    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hms_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hms_clock
//  Description : Self-checking bench for hms_clock. Drives a 24-hour and a
//                12-hour instance from shared stimulus; each vector names
//                the instance it checks. Expected results are queued when a
//                vector is driven and popped when the outputs are sampled.
//                Honours HMS_ALARM_EN for the expected alarm behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hms_clock;

`ifdef HMS_ALARM_EN
    localparam logic ALM = 1'b1;
`else
    localparam logic ALM = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          sel;      // 0: 24-hour instance, 1: 12-hour instance
        logic        tick, run, lv;
        logic [23:0] lt;
        logic        aw;
        logic [15:0] at;
        logic [7:0]  hh, mm, ss;
        logic        mc, dp, dn, er, rdy, hit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tick, run, load_valid, alarm_wr;
    logic [23:0] load_time;
    logic [15:0] alarm_time;

    logic [7:0]  hour_24, min_24, sec_24, hour_12, min_12, sec_12;
    logic        rdy_24, dn_24, er_24, mc_24, dp_24, hit_24;
    logic        rdy_12, dn_12, er_12, mc_12, dp_12, hit_12;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    hms_clock #(.HOURS_24(1)) dut24 (
        .clk(clk), .rstn(rstn), .tick(tick), .run(run),
        .load_valid(load_valid), .load_ready(rdy_24), .load_time(load_time),
        .load_done(dn_24), .load_err(er_24),
        .alarm_wr(alarm_wr), .alarm_time(alarm_time),
        .hour(hour_24), .min(min_24), .sec(sec_24),
        .min_carry(mc_24), .day_pulse(dp_24), .alarm_hit(hit_24)
    );

    hms_clock #(.HOURS_24(0)) dut12 (
        .clk(clk), .rstn(rstn), .tick(tick), .run(run),
        .load_valid(load_valid), .load_ready(rdy_12), .load_time(load_time),
        .load_done(dn_12), .load_err(er_12),
        .alarm_wr(alarm_wr), .alarm_time(alarm_time),
        .hour(hour_12), .min(min_12), .sec(sec_12),
        .min_carry(mc_12), .day_pulse(dp_12), .alarm_hit(hit_12)
    );

    function automatic vec_t mkv(input string name, input bit sel,
                                 input logic tk, input logic rn, input logic lv,
                                 input logic [23:0] lt, input logic [23:0] t,
                                 input logic mc, input logic dp, input logic dn,
                                 input logic er, input logic rdy,
                                 input logic hit = 1'b0, input logic aw = 1'b0,
                                 input logic [15:0] at = 16'h0000);
        vec_t v;
        v.name = name; v.sel = sel; v.tick = tk; v.run = rn; v.lv = lv; v.lt = lt;
        v.aw = aw; v.at = at;
        v.hh = t[23:16]; v.mm = t[15:8]; v.ss = t[7:0];
        v.mc = mc; v.dp = dp; v.dn = dn; v.er = er; v.rdy = rdy; v.hit = hit;
        return v;
    endfunction

    task automatic compare_front();
        vec_t        e;
        logic [29:0] act, exp;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: got no queued expectation, want one");
            return;
        end
        e = sb.pop_front();
        if (e.sel)
            act = {hour_12, min_12, sec_12, mc_12, dp_12, dn_12, er_12, rdy_12, hit_12};
        else
            act = {hour_24, min_24, sec_24, mc_24, dp_24, dn_24, er_24, rdy_24, hit_24};
        exp = {e.hh, e.mm, e.ss, e.mc, e.dp, e.dn, e.er, e.rdy, e.hit};
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h:%h:%h mc=%b dp=%b done=%b err=%b rdy=%b hit=%b, want %h:%h:%h mc=%b dp=%b done=%b err=%b rdy=%b hit=%b",
                     e.name, act[29:22], act[21:14], act[13:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     e.hh, e.mm, e.ss, e.mc, e.dp, e.dn, e.er, e.rdy, e.hit);
        end
    endtask

    // Drive one cycle of stimulus, then check the outputs after the edge.
    task automatic apply(input vec_t v);
        tick = v.tick; run = v.run; load_valid = v.lv; load_time = v.lt;
        alarm_wr = v.aw; alarm_time = v.at;
        sb.push_back(v);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // Check without advancing the clock (async reset behaviour).
    task automatic check_now(input vec_t v);
        sb.push_back(v);
        compare_front();
    endtask

    task automatic idle_inputs();
        tick = 1'b0; run = 1'b1; load_valid = 1'b0; load_time = 24'h0;
        alarm_wr = 1'b0; alarm_time = 16'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now(mkv("reset_24", 0, 0, 1, 0, 0, 24'h000000, 0, 0, 0, 0, 1));
        check_now(mkv("reset_12", 1, 0, 1, 0, 0, 24'h120000, 0, 0, 0, 0, 1));
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- 24-hour instance ----------------
        //                name          sel tk rn lv load_time   expected   mc dp dn er rdy
        tbl.push_back(mkv("first_tick",   0, 1, 1, 0, 24'h000000, 24'h000001, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("idle",         0, 0, 1, 0, 24'h000000, 24'h000001, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("run0_tick",    0, 1, 0, 0, 24'h000000, 24'h000001, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_235958",   0, 0, 1, 1, 24'h235958, 24'h000001, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("com_235958",   0, 0, 1, 0, 24'h000000, 24'h235958, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("tick_235959",  0, 1, 1, 0, 24'h000000, 24'h235959, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("midnight",     0, 1, 1, 0, 24'h000000, 24'h000000, 1, 1, 0, 0, 1));
        tbl.push_back(mkv("midnight_end", 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_240000",   0, 0, 1, 1, 24'h240000, 24'h000000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("err_240000",   0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 1, 1));
        tbl.push_back(mkv("acc_126000",   0, 0, 1, 1, 24'h126000, 24'h000000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("err_126000",   0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 1, 1));
        tbl.push_back(mkv("acc_123A00",   0, 0, 1, 1, 24'h123A00, 24'h000000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("err_123A00",   0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 1, 1));
        tbl.push_back(mkv("err_clear",    0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_0A0000",   0, 0, 1, 1, 24'h0A0000, 24'h000000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("err_tick",     0, 1, 1, 0, 24'h000000, 24'h000001, 0, 0, 0, 1, 1));
        tbl.push_back(mkv("acc_102030_t", 0, 1, 1, 1, 24'h102030, 24'h000002, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("com_102030_t", 0, 1, 1, 0, 24'h000000, 24'h102030, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("tick_102031",  0, 1, 1, 0, 24'h000000, 24'h102031, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("idle_102031",  0, 0, 1, 0, 24'h000000, 24'h102031, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_095959",   0, 0, 1, 1, 24'h095959, 24'h102031, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("com_095959",   0, 0, 1, 0, 24'h000000, 24'h095959, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("hour_roll",    0, 1, 1, 0, 24'h000000, 24'h100000, 1, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_000009",   0, 0, 1, 1, 24'h000009, 24'h100000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("com_000009",   0, 0, 1, 0, 24'h000000, 24'h000009, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("digit_carry",  0, 1, 1, 0, 24'h000000, 24'h000010, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_010203",   0, 0, 1, 1, 24'h010203, 24'h000010, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("hold_valid",   0, 0, 1, 1, 24'h112233, 24'h010203, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("acc_040506",   0, 0, 1, 1, 24'h040506, 24'h010203, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("com_040506",   0, 0, 1, 0, 24'h000000, 24'h040506, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("idle_040506",  0, 0, 1, 0, 24'h000000, 24'h040506, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("acc_050505",   0, 0, 1, 1, 24'h050505, 24'h040506, 0, 0, 0, 0, 0));
        run_table();

        // Reset during CHECK: load aborted, no done/err pulse.
        idle_inputs();
        rstn = 1'b0;
        #1;
        check_now(mkv("rst_midload", 0, 0, 1, 0, 0, 24'h000000, 0, 0, 0, 0, 1));
        @(negedge clk);
        rstn = 1'b1;
        apply(mkv("rst_no_pulse", 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 0, 1));

        // ---------------- 12-hour instance ----------------
        do_reset();
        tbl.push_back(mkv("h12_reset",    1, 0, 1, 0, 24'h000000, 24'h120000, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("h12_tick",     1, 1, 1, 0, 24'h000000, 24'h120001, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("h12_acc_1259", 1, 0, 1, 1, 24'h125959, 24'h120001, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("h12_com_1259", 1, 0, 1, 0, 24'h000000, 24'h125959, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("h12_dayroll",  1, 1, 1, 0, 24'h000000, 24'h010000, 1, 1, 0, 0, 1));
        tbl.push_back(mkv("h12_idle",     1, 0, 1, 0, 24'h000000, 24'h010000, 0, 0, 0, 0, 1));
        tbl.push_back(mkv("h12_acc_0010", 1, 0, 1, 1, 24'h001000, 24'h010000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("h12_err_0010", 1, 0, 1, 0, 24'h000000, 24'h010000, 0, 0, 0, 1, 1));
        tbl.push_back(mkv("h12_acc_1159", 1, 0, 1, 1, 24'h115959, 24'h010000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("h12_com_1159", 1, 0, 1, 0, 24'h000000, 24'h115959, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("h12_11_to_12", 1, 1, 1, 0, 24'h000000, 24'h120000, 1, 0, 0, 0, 1));
        tbl.push_back(mkv("h12_acc_13",   1, 0, 1, 1, 24'h130000, 24'h120000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("h12_err_13",   1, 0, 1, 0, 24'h000000, 24'h120000, 0, 0, 0, 1, 1));
        tbl.push_back(mkv("h12_acc_0959", 1, 0, 1, 1, 24'h095959, 24'h120000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("h12_com_0959", 1, 0, 1, 0, 24'h000000, 24'h095959, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("h12_09_to_10", 1, 1, 1, 0, 24'h000000, 24'h100000, 1, 0, 0, 0, 1));
        run_table();

        // ---------------- alarm (24-hour instance) ----------------
        do_reset();
        tbl.push_back(mkv("al_write",     0, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0, 0, 1, 0, 1, 16'h0730));
        tbl.push_back(mkv("al_acc",       0, 0, 1, 1, 24'h072959, 24'h000000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("al_com",       0, 0, 1, 0, 24'h000000, 24'h072959, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("al_tick",      0, 1, 1, 0, 24'h000000, 24'h073000, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mkv("al_hit",       0, 0, 1, 0, 24'h000000, 24'h073000, 0, 0, 0, 0, 1, ALM));
        tbl.push_back(mkv("al_hit_end",   0, 0, 1, 0, 24'h000000, 24'h073000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv("al_ld_acc",    0, 0, 1, 1, 24'h073000, 24'h073000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("al_ld_com",    0, 0, 1, 0, 24'h000000, 24'h073000, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mkv("al_ld_nohit",  0, 0, 1, 0, 24'h000000, 24'h073000, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv("al_bad_write", 0, 0, 1, 0, 24'h000000, 24'h073000, 0, 0, 0, 0, 1, 0, 1, 16'h2500));
        tbl.push_back(mkv("al_acc2",      0, 0, 1, 1, 24'h072959, 24'h073000, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("al_com2",      0, 0, 1, 0, 24'h000000, 24'h072959, 0, 0, 1, 0, 1));
        tbl.push_back(mkv("al_tick2",     0, 1, 1, 0, 24'h000000, 24'h073000, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mkv("al_hit_kept",  0, 0, 1, 0, 24'h000000, 24'h073000, 0, 0, 0, 0, 1, ALM));
        tbl.push_back(mkv("al_tick_past", 0, 1, 1, 0, 24'h000000, 24'h073001, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv("al_no_rehit",  0, 0, 1, 0, 24'h000000, 24'h073001, 0, 0, 0, 0, 1, 0));
        run_table();

        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d leftover expectations, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
